// File: rtl/axis_aiu_bridge.sv
// AXI-Stream frame bridge: buffers one input frame for the AIU to read,
// waits for the AIU to finish, then streams the result words back out.
module axis_aiu_bridge #(
    parameter int DATA_W    = 32,
    parameter int IN_DEPTH  = 8,
    parameter int OUT_DEPTH = 4,
    parameter int IA_W      = $clog2(IN_DEPTH),
    parameter int OA_W      = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1,
    parameter int CNT_W     = $clog2(IN_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_start,
    output logic              ex_startAck,
    input  logic              auto_restart,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              waitSt,
    input  logic              waitFin,
    input  logic [IA_W-1:0]   inp_adr,
    output logic [DATA_W-1:0] inp_data,
    output logic [OA_W-1:0]   out_adr,
    input  logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  in_count,
    output logic              frame_err
);

    typedef enum logic [2:0] {IDLE, ACK, RECV, DRAIN, COMPUTE, SEND} state_t;

    state_t            state, next_state;
    logic [DATA_W-1:0] mem [IN_DEPTH];
    logic [IA_W-1:0]   wr_ptr;
    logic [OA_W-1:0]   rd_ptr;
    logic              in_beat, out_beat, full_beat, last_word, enter_recv;

    assign in_beat    = s_valid && s_ready;
    assign out_beat   = m_valid && m_ready;
    assign full_beat  = (in_count == CNT_W'(IN_DEPTH - 1));
    assign last_word  = (rd_ptr == OA_W'(OUT_DEPTH - 1));
    assign enter_recv = (next_state == RECV) && (state != RECV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ex_start) next_state = ACK;
            ACK:     if (!ex_start) next_state = RECV;
            RECV: begin
                if (in_beat) begin
                    if (s_last) begin
                        next_state = COMPUTE;
                    end else if (full_beat) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN:   if (in_beat && s_last) next_state = COMPUTE;
            COMPUTE: if (waitFin) next_state = SEND;
            SEND: begin
                if (out_beat && last_word) begin
                    next_state = auto_restart ? RECV : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ex_startAck = 1'b0;
        s_ready     = 1'b0;
        waitSt      = 1'b0;
        m_valid     = 1'b0;
        m_last      = 1'b0;
        m_data      = '0;
        out_adr     = '0;
        case (state)
            ACK:     ex_startAck = 1'b1;
            RECV:    s_ready = 1'b1;
            DRAIN:   s_ready = 1'b1;
            COMPUTE: waitSt = 1'b1;
            SEND: begin
                m_valid = 1'b1;
                m_last  = last_word;
                m_data  = out_data;
                out_adr = rd_ptr;
            end
            default: ;
        endcase
    end

    // Words beyond the stored count read as zero, padding short frames.
    always_comb begin
        inp_data = '0;
        if (CNT_W'(inp_adr) < in_count) begin
            inp_data = mem[inp_adr];
        end
    end

    always_ff @(posedge clk) begin
        if (state == RECV && in_beat) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            in_count  <= '0;
            frame_err <= 1'b0;
        end else if (enter_recv) begin
            wr_ptr    <= '0;
            in_count  <= '0;
            frame_err <= 1'b0;
        end else if (state == RECV && in_beat) begin
            wr_ptr   <= wr_ptr + 1'b1;
            in_count <= in_count + 1'b1;
            // Error when the frame ends early or overruns the buffer.
            if (s_last != full_beat) begin
                frame_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (state == COMPUTE && waitFin) begin
            rd_ptr <= '0;
        end else if (out_beat) begin
            rd_ptr <= last_word ? '0 : rd_ptr + 1'b1;
        end
    end

endmodule

// File: doc/axis_aiu_bridge.md
# axis_aiu_bridge

Parametrised AXI-Stream frame bridge between the DMA stream and the AIU compute core. It buffers one input frame of up to IN_DEPTH words, hands it to the AIU through an address/data read port, and waits for the AIU's done handshake. It then streams OUT_DEPTH result words back out on an AXI-Stream master with TLAST. It adds three things: configurable width and depth, short- and long-frame handling with an error flag, and an auto-restart mode for back-to-back frames.

## Interface
- DATA_W, 32, stream and buffer word width.
- IN_DEPTH, 8, input buffer words (≥2).
- OUT_DEPTH, 4, output words per frame (≥1).
- IA_W, $clog2(IN_DEPTH), inp_adr width; OA_W, $clog2(OUT_DEPTH) (min 1), out_adr width; CNT_W, $clog2(IN_DEPTH+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_start  in  1  frame start request (level).
- ex_startAck  out  1  start acknowledge.
- auto_restart  in  1  sampled at end of SEND; 1 = return to RECV without a new ex_start.
- s_data  in  DATA_W  slave stream data.
- s_valid  in  1  slave stream valid.
- s_last  in  1  slave stream last.
- s_ready  out  1  slave stream ready.
- m_data  out  DATA_W  master stream data.
- m_valid  out  1  master stream valid.
- m_last  out  1  master stream last.
- m_ready  in  1  master stream ready.
- waitSt  out  1  frame ready; AIU may compute.
- waitFin  in  1  AIU done.
- inp_adr  in  IA_W  AIU read address.
- inp_data  out  DATA_W  AIU read data, combinational.
- out_adr  out  OA_W  result-buffer address driven to the AIU output buffer.
- out_data  in  DATA_W  result word at out_adr, combinational from the AIU side.
- in_count  out  CNT_W  words stored in the current frame.
- frame_err  out  1  sticky flag: current frame was short or long.

## Operation
- States: IDLE, ACK, RECV, DRAIN, COMPUTE, SEND.
- IDLE: all handshake outputs 0. When ex_start=1, go to ACK.
- ACK: ex_startAck=1. When ex_start=0, go to RECV.
- Entry to RECV from any state clears wr_ptr, in_count and frame_err.
- RECV: s_ready=1. Each s_valid&&s_ready beat writes buf[wr_ptr] and increments wr_ptr and in_count.
  - Beat with s_last=1 goes to COMPUTE. If that beat is not word IN_DEPTH, frame_err=1 (short frame).
  - Beat number IN_DEPTH with s_last=0 goes to DRAIN.
- DRAIN: s_ready=1. Beats are discarded and the buffer is unchanged. frame_err=1 on entry. A beat with s_last goes to COMPUTE.
- COMPUTE: waitSt=1 and s_ready=0. When waitFin=1 is sampled, clear rd_ptr and go to SEND.
- inp_data = buf[inp_adr] when inp_adr < in_count, else 0. This zero-pads short frames. Valid in every state.
- SEND: m_valid=1, out_adr=rd_ptr, m_data=out_data, m_last = (rd_ptr==OUT_DEPTH-1).
  - Each m_valid&&m_ready increments rd_ptr.
  - out_adr changes only on a handshake, so m_data is stable while stalled.
  - Last handshake goes to RECV if auto_restart=1, else IDLE.
- out_adr is 0 outside SEND.

## Timing
- Reset (async, any state): state=IDLE, wr_ptr=rd_ptr=in_count=0, frame_err=0.
  - Outputs: ex_startAck=s_ready=m_valid=m_last=waitSt=0, out_adr=0.
  - Buffer contents are not cleared; they are masked because in_count=0.
  - Reset mid-RECV or mid-SEND simply abandons the frame.
- ex_startAck rises 1 cycle after ex_start is sampled high. s_ready rises 1 cycle after ex_start is sampled low.
- s_ready drops in the cycle after the s_last beat. It is never high in COMPUTE or SEND, so no input backpressure is needed within those states.
- waitSt rises 1 cycle after the terminating beat. It falls and m_valid rises 1 cycle after waitFin is sampled.
- Throughput: one word per cycle in RECV and SEND when the partner is always ready.
- m_valid holds high through m_ready=0 stalls.
- ex_start asserted while not in IDLE is ignored.
- waitFin outside COMPUTE is ignored.
- s_last on the very first beat gives in_count=1 and frame_err=1.
- Auto-restart: the cycle after the last m handshake, state is RECV with s_ready=1.

## Test plan
- Nominal (defaults), 4-word output path:
  - Stimulus: start handshake, beats 1..8 with s_last on beat 8, AIU reads adr 0..7, waitFin, m_ready toggling every cycle; out_data = out_adr+13.
  - Required: inp_data 1..8, frame_err=0, m_data 13,14,15,16, m_last only with 16, back to IDLE.
- Short frame: beats 1..3 with s_last on beat 3 -> in_count=3, frame_err=1, inp_adr 3..7 reads 0.
- Long frame: 10 beats with s_last on beat 10 -> buffer holds 1..8, beats 9 and 10 dropped, frame_err=1, waitSt rises after beat 10.
- Backpressure and auto-restart:
  - Stimulus: m_ready held low for 5 cycles mid-SEND, with auto_restart=1.
  - Required: m_data and out_adr stable while stalled, no beat lost, s_ready=1 one cycle after the final handshake without ex_start.
- Reset mid-RECV after 4 beats: all outputs at reset values immediately (async), in_count=0, next ex_start starts a clean frame.
- Parameter sweep DATA_W=16, IN_DEPTH=5, OUT_DEPTH=1: 5-beat frame -> frame_err=0, single output beat with m_last=1.
